// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the data-memory access stage.
// Size codes match the control unit; FSM state codes are local.
package mem_access_unit_pkg;

  localparam logic [1:0] MEM_SIZE_WORD = 2'd0;
  localparam logic [1:0] MEM_SIZE_HALF = 2'd1;
  localparam logic [1:0] MEM_SIZE_BYTE = 2'd2;
  localparam logic [1:0] MEM_SIZE_ILL  = 2'd3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic logic size_ok(
    input logic [1:0] size,
    input logic [1:0] lo
  );
    logic ok;
    ok = 1'b0;
    case (size)
      MEM_SIZE_WORD: ok = (lo == 2'b00);
      MEM_SIZE_HALF: ok = !lo[0];
      MEM_SIZE_BYTE: ok = 1'b1;
      default:       ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_lane_format.sv
// Byte-lane formatting: store enables/replication, load extract/extend.
// Ports: size, ext, lo (addr[1:0]), st_data, ld_word in; be, st_word, ld_data out.
module mem_lane_format
  import mem_access_unit_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        ext,
  input  logic [1:0]  lo,
  input  logic [31:0] st_data,
  input  logic [31:0] ld_word,
  output logic [3:0]  be,
  output logic [31:0] st_word,
  output logic [31:0] ld_data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    be      = 4'b0000;
    st_word = 32'h0;
    ld_data = 32'h0;
    b       = 8'h0;
    h       = 16'h0;
    case (lo)
      2'd0:    b = ld_word[7:0];
      2'd1:    b = ld_word[15:8];
      2'd2:    b = ld_word[23:16];
      default: b = ld_word[31:24];
    endcase
    h = lo[1] ? ld_word[31:16] : ld_word[15:0];
    case (size)
      MEM_SIZE_WORD: begin
        be      = 4'b1111;
        st_word = st_data;
        ld_data = ld_word;
      end
      MEM_SIZE_HALF: begin
        be      = lo[1] ? 4'b1100 : 4'b0011;
        st_word = {2{st_data[15:0]}};
        ld_data = ext ? {16'h0, h} : {{16{h[15]}}, h};
      end
      MEM_SIZE_BYTE: begin
        be      = 4'b0001 << lo;
        st_word = {4{st_data[7:0]}};
        ld_data = ext ? {24'h0, b} : {{24{b[7]}}, b};
      end
      default: begin
        be      = 4'b0000;
        st_word = 32'h0;
        ld_data = 32'h0;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Data-memory access stage: req/ack bus master with timeout.
// Ports: control (memRead/memWrite/size/ext), addr/wrData, rdData, stall, flags, bus.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [1:0]  memDataSize,
  input  logic        memBitExtend,
  input  logic [31:0] addr,
  input  logic [31:0] wrData,
  output logic [31:0] rdData,
  output logic        stall,
  output logic        misaligned,
  output logic        busErr,
  output logic        busReq,
  output logic        busWe,
  output logic [31:0] busAddr,
  output logic [3:0]  busBe,
  output logic [31:0] busWdata,
  input  logic        busAck,
  input  logic [31:0] busRdata
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_q, req_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rd_q, rd_d;
  logic          mis_q, mis_d;
  logic          err_q, err_d;
  logic [1:0]    size_q, size_d;
  logic          ext_q, ext_d;
  logic [1:0]    lo_q, lo_d;
  logic          ld_q, ld_d;

  logic          acc, legal, tmo, idle;
  logic [1:0]    f_size, f_lo;
  logic          f_ext;
  logic [3:0]    f_be;
  logic [31:0]   f_st, f_ld;

  assign idle  = (state_q == ST_IDLE);
  assign acc   = memRead | memWrite;
  assign legal = (memRead ^ memWrite)
               & size_ok(memDataSize, addr[1:0]);
  assign tmo   = (TIMEOUT != 0)
               && (32'(cnt_q) == TIMEOUT - 1);

  // Store lanes come from live inputs; load lanes from the latched access.
  assign f_size = idle ? memDataSize  : size_q;
  assign f_ext  = idle ? memBitExtend : ext_q;
  assign f_lo   = idle ? addr[1:0]    : lo_q;

  mem_lane_format u_fmt (
    .size    (f_size),
    .ext     (f_ext),
    .lo      (f_lo),
    .st_data (wrData),
    .ld_word (busRdata),
    .be      (f_be),
    .st_word (f_st),
    .ld_data (f_ld)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    mis_d   = 1'b0;
    err_d   = 1'b0;
    size_d  = size_q;
    ext_d   = ext_q;
    lo_d    = lo_q;
    ld_d    = ld_q;
    case (state_q)
      ST_IDLE: begin
        if (acc && legal) begin
          req_d   = 1'b1;
          we_d    = memWrite;
          addr_d  = {addr[31:2], 2'b00};
          be_d    = f_be;
          wdata_d = f_st;
          size_d  = memDataSize;
          ext_d   = memBitExtend;
          lo_d    = addr[1:0];
          ld_d    = memRead;
          cnt_d   = '0;
          state_d = ST_BUSY;
        end else if (acc) begin
          mis_d = 1'b1;
        end
      end
      ST_BUSY: begin
        if (busAck) begin
          req_d   = 1'b0;
          if (ld_q) rd_d = f_ld;
          state_d = ST_DONE;
        end else if (tmo) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          if (ld_q) rd_d = 32'h0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      be_q    <= 4'h0;
      wdata_q <= 32'h0;
      rd_q    <= 32'h0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= 2'd0;
      ext_q   <= 1'b0;
      lo_q    <= 2'd0;
      ld_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      mis_q   <= mis_d;
      err_q   <= err_d;
      size_q  <= size_d;
      ext_q   <= ext_d;
      lo_q    <= lo_d;
      ld_q    <= ld_d;
    end
  end

  // DONE drops stall so the instruction retires on that edge.
  assign stall = !rst
               && ((idle && acc && legal)
                   || (state_q == ST_BUSY));

  assign rdData     = rd_q;
  assign misaligned = mis_q;
  assign busErr     = err_q;
  assign busReq     = req_q;
  assign busWe      = we_q;
  assign busAddr    = addr_q;
  assign busBe      = be_q;
  assign busWdata   = wdata_q;

endmodule
